// File: rtl/mem_xfer_pkg.sv
// mem_xfer_pkg: shared state encoding, default geometry and line-offset helper
// for the cache-line memory transfer engine.
`default_nettype none

package mem_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_LINE_WORDS = 8;

  // Byte offset bits within a line: word index bits plus the byte-in-word bit.
  function automatic int offset_bits(input int line_words);
    return $clog2(line_words) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_line_xfer.sv
// mem_line_xfer: moves one aligned cache line between the cache and the 16-bit
// data memory, one word per cycle (fill = sequential reads, write-back = writes).
`default_nettype none

module mem_line_xfer
  import mem_xfer_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_wr,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [16*LINE_WORDS-1:0] wr_line,
  output logic [16*LINE_WORDS-1:0] rd_line,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [15:0]              mem_wdata,
  input  logic [15:0]              mem_rdata
);

  localparam int OFFSET_BITS = offset_bits(LINE_WORDS);
  localparam int CNT_W       = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0]      LAST_CNT    = CNT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << OFFSET_BITS) - 1);

  state_t                     r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic [ADDR_WIDTH-1:0]      r_base;
  logic                       r_wr;
  logic [16*LINE_WORDS-1:0]   r_wline;
  logic [16*LINE_WORDS-1:0]   r_rd_line;
  logic                       r_done;
  logic                       r_mem_en;
  logic                       r_mem_wr;
  logic [ADDR_WIDTH-1:0]      r_mem_addr;
  logic [15:0]                r_mem_wdata;

  logic [ADDR_WIDTH-1:0]      w_base;
  logic [CNT_W-1:0]           w_cnt_nxt;
  logic [ADDR_WIDTH-1:0]      w_next_addr;
  logic [15:0]                w_next_wdata;

  assign w_base       = req_addr & ~OFFSET_MASK;
  assign w_cnt_nxt    = r_cnt + CNT_W'(1);
  // Line is aligned, so OR-ing the word offset into the base never carries.
  assign w_next_addr  = r_base | {{(ADDR_WIDTH-CNT_W-1){1'b0}}, w_cnt_nxt, 1'b0};
  assign w_next_wdata = r_wline[{w_cnt_nxt, 4'b0000} +: 16];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_base      <= '0;
      r_wr        <= 1'b0;
      r_wline     <= '0;
      r_rd_line   <= '0;
      r_done      <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (req_valid) begin
            r_base      <= w_base;
            r_wr        <= req_wr;
            r_wline     <= wr_line;
            r_cnt       <= '0;
            r_state     <= XFER;
            r_mem_en    <= 1'b1;
            r_mem_wr    <= req_wr;
            r_mem_addr  <= w_base;
            r_mem_wdata <= req_wr ? wr_line[15:0] : 16'h0000;
          end
        end
        XFER: begin
          if (!r_wr) begin
            r_rd_line[{r_cnt, 4'b0000} +: 16] <= mem_rdata;
          end
          if (r_cnt == LAST_CNT) begin
            r_state     <= DONE;
            r_done      <= 1'b1;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
          end else begin
            r_cnt       <= w_cnt_nxt;
            r_mem_addr  <= w_next_addr;
            r_mem_wdata <= r_wr ? w_next_wdata : 16'h0000;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign rd_line   = r_rd_line;
  assign mem_en    = r_mem_en;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_line_xfer.sv
// tb_mem_line_xfer: directed, table-driven bench for mem_line_xfer with a
// behavioural 64 KiB word memory and a running protocol monitor.
`default_nettype none

module tb_mem_line_xfer;
  import mem_xfer_pkg::*;

  localparam int AW = 16;
  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, req_ready, req_wr;
  logic [AW-1:0]   req_addr;
  logic [16*LW-1:0] wr_line, rd_line;
  logic            busy, done, mem_en, mem_wr;
  logic [AW-1:0]   mem_addr;
  logic [15:0]     mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_line_xfer #(.ADDR_WIDTH(AW), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .wr_line(wr_line), .rd_line(rd_line),
    .busy(busy), .done(done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Word-addressed memory; preloaded with word i = 16'h1000 + i while mem_load.
  logic [15:0] mem [0:32767];
  logic        mem_load;
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 32768; i++) mem[i] <= 16'h1000 + 16'(i);
    end else if (mem_en && mem_wr) begin
      mem[mem_addr[15:1]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[15:1]];

  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;
  int done_exp  = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst || mem_load) begin
      prev_done = 1'b0;
    end else begin
      check("proto_wr_without_en", 128'(mem_wr & ~mem_en), 128'(0));
      check("proto_addr_lsb", 128'(mem_addr[0]), 128'(0));
      if (!busy) check("proto_idle_mem_zero", 128'({mem_en, mem_wr, mem_addr, mem_wdata}), 128'(0));
      check("proto_done_single_cycle", 128'(done & prev_done), 128'(0));
      if (done) done_seen++;
      prev_done = done;
    end
  end

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wbase;
    logic [15:0] exp_base;
    logic [15:0] exp_rd0;
  } vec_t;

  vec_t vecs [7];

  task automatic run_xfer(input vec_t v);
    logic [15:0] exp_wd;
    @(negedge clk);
    check("accept_ready", 128'(req_ready), 128'(1));
    req_valid = 1'b1;
    req_wr    = v.wr;
    req_addr  = v.addr;
    for (int k = 0; k < LW; k++) wr_line[k*16 +: 16] = v.wbase + 16'(k);
    for (int k = 0; k < LW; k++) begin
      @(negedge clk);
      if (k == 0) begin
        // Garbage after accept: the engine must have latched its request.
        req_valid = 1'b0;
        req_wr    = ~v.wr;
        req_addr  = 16'hFFFF;
        wr_line   = '1;
      end
      exp_wd = v.wr ? (v.wbase + 16'(k)) : 16'h0000;
      check("xfer_mem_en", 128'(mem_en), 128'(1));
      check("xfer_mem_wr", 128'(mem_wr), 128'(v.wr));
      check("xfer_mem_addr", 128'(mem_addr), 128'(v.exp_base + 16'(2*k)));
      check("xfer_mem_wdata", 128'(mem_wdata), 128'(exp_wd));
      check("xfer_busy_ready_done", 128'({busy, req_ready, done}), 128'(3'b100));
    end
    @(negedge clk);
    check("done_pulse", 128'({done, busy, mem_en, mem_wr}), 128'(4'b1100));
    done_exp++;
    @(negedge clk);
    check("after_done", 128'({done, busy, req_ready}), 128'(3'b001));
    for (int k = 0; k < LW; k++)
      check("rd_line_word", 128'(rd_line[k*16 +: 16]), 128'(v.exp_rd0 + 16'(k)));
  endtask

  int cyc;

  initial begin
    vecs[0] = '{wr: 1'b0, addr: 16'h0024, wbase: 16'h0000, exp_base: 16'h0020, exp_rd0: 16'h1010};
    vecs[1] = '{wr: 1'b1, addr: 16'h0100, wbase: 16'hA500, exp_base: 16'h0100, exp_rd0: 16'h1010};
    vecs[2] = '{wr: 1'b0, addr: 16'h0100, wbase: 16'h0000, exp_base: 16'h0100, exp_rd0: 16'hA500};
    vecs[3] = '{wr: 1'b0, addr: 16'hFFF0, wbase: 16'h0000, exp_base: 16'hFFF0, exp_rd0: 16'h8FF8};
    vecs[4] = '{wr: 1'b0, addr: 16'h003F, wbase: 16'h0000, exp_base: 16'h0030, exp_rd0: 16'h1018};
    vecs[5] = '{wr: 1'b1, addr: 16'h0207, wbase: 16'h5A00, exp_base: 16'h0200, exp_rd0: 16'h1018};
    vecs[6] = '{wr: 1'b0, addr: 16'h0200, wbase: 16'h0000, exp_base: 16'h0200, exp_rd0: 16'h5A00};

    rst = 1'b1; mem_load = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; wr_line = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_mem_outputs", 128'({mem_en, mem_wr, mem_addr, mem_wdata}), 128'(0));
    check("reset_done_busy", 128'({done, busy}), 128'(0));
    check("reset_rd_line", rd_line, 128'(0));
    mem_load = 1'b0;
    rst = 1'b0;
    #1;
    check("reset_ready", 128'(req_ready), 128'(1));

    for (int i = 0; i < 7; i++) run_xfer(vecs[i]);

    // Reset during word 3 of a write-back to 0x0300.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0300;
    for (int k = 0; k < LW; k++) wr_line[k*16 +: 16] = 16'hC300 + 16'(k);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_word3_addr", 128'({mem_en, mem_wr, mem_addr}), 128'({2'b11, 16'h0306}));
    #1 rst = 1'b1;
    #1;
    check("abort_mem_drop", 128'({mem_en, mem_wr}), 128'(0));
    check("abort_state_idle", 128'({busy, req_ready, done}), 128'(3'b010));
    check("abort_rd_line_clear", rd_line, 128'(0));
    repeat (2) begin
      @(negedge clk);
      check("abort_no_done", 128'(done), 128'(0));
    end
    rst = 1'b0;
    for (int k = 0; k < LW; k++)
      check("abort_mem_word", 128'(mem[16'h0180 + 16'(k)]),
            128'(k < 3 ? 16'hC300 + 16'(k) : 16'h1180 + 16'(k)));

    // req_valid held high across a transfer with a changing address.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0040;
    check("hold_first_ready", 128'(req_ready), 128'(1));
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 0) req_addr = 16'h0060;
      check("hold_ready_low", 128'(req_ready), 128'(0));
      if (k < 8) check("hold_first_addr", 128'(mem_addr), 128'(16'h0040 + 16'(2*k)));
    end
    @(negedge clk);
    check("hold_ready_t10", 128'({req_ready, done, mem_en}), 128'(3'b100));
    @(negedge clk);
    check("hold_second_start", 128'({busy, mem_en, mem_addr}), 128'({2'b11, 16'h0060}));
    req_valid = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("hold_second_done", 128'(done), 128'(1));
    done_exp += 2;
    @(negedge clk);
    for (int k = 0; k < LW; k++)
      check("hold_rd_line_word", 128'(rd_line[k*16 +: 16]), 128'(16'h1030 + 16'(k)));

    repeat (2) @(negedge clk);
    check("done_pulse_count", 128'(done_seen), 128'(done_exp));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_line_xfer.md
Name: mem_line_xfer

Overview:
- Initiator for the single-cycle, byte-addressed, 16-bit data memory. It moves one aligned cache line of LINE_WORDS words between the cache and memory.
- Fill (read) requests assemble the line from sequential word reads. Write-back requests issue sequential word writes.
- Sits between the cache controller FSM and the data memory. It is the only master of the memory port.

Parameters:
- ADDR_WIDTH, 16, byte-address width, matches memory.
- LINE_WORDS, 8, 16-bit words per line (16-byte line); power of two, 2..32.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  transfer request
- req_ready  out  1  high only in IDLE; request accepted on req_valid & req_ready at posedge
- req_wr  in  1  1 = write-back line, 0 = fill line
- req_addr  in  ADDR_WIDTH  line byte address; low OFFSET_BITS forced to 0 internally
- wr_line  in  16*LINE_WORDS  write-back data, word 0 at [15:0]
- rd_line  out  16*LINE_WORDS  filled line, word 0 at [15:0]
- busy  out  1  high in XFER and DONE
- done  out  1  one-cycle pulse when the transfer completes
- mem_en  out  1  memory enable
- mem_wr  out  1  memory write strobe
- mem_addr  out  ADDR_WIDTH  memory byte address, bit 0 always 0
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data (combinational, zero-latency)

Behaviour:
- Reset (async, immediate):
  - state = IDLE, cnt = 0.
  - rd_line = 0, done = 0, busy = 0.
  - mem_en/mem_wr/mem_addr/mem_wdata = 0; req_ready = 1 after reset deasserts.
- OFFSET_BITS = log2(LINE_WORDS) + 1.
- Accept: on the posedge where state = IDLE and req_valid = 1:
  - latch base = req_addr with low OFFSET_BITS cleared;
  - latch req_wr and wr_line;
  - cnt = 0, go to XFER.
- XFER, one word per cycle for cnt = 0..LINE_WORDS-1:
  - mem_en = 1, mem_wr = latched req_wr.
  - mem_addr = base + 2*cnt. Width is ADDR_WIDTH; the line is aligned, so no carry out of the offset field.
  - mem_wdata = latched word cnt when writing, else 0.
  - Read: at the posedge ending the cycle, rd_line word cnt <= mem_rdata.
  - cnt increments each cycle. When cnt = LINE_WORDS-1, go to DONE.
- DONE (one cycle): done = 1, mem_en = 0, mem_wr = 0. Next state is IDLE.
- Latency: accept at edge t; words on cycles t+1..t+LINE_WORDS; done high on cycle t+LINE_WORDS+1; req_ready high again at t+LINE_WORDS+2.
- Outside XFER, all mem_* outputs are 0. mem_wr is never high while mem_en is low. There is never a concurrent read and write.
- req_valid outside IDLE is ignored (no queueing). Request inputs are sampled only at accept.
- rd_line:
  - updated only by fills; write-backs leave it unchanged;
  - stable from done until the next fill starts;
  - word k is overwritten in cycle k of a fill.
- Top line of the address space (base = 2^ADDR_WIDTH - 2*LINE_WORDS): last word address = 2^ADDR_WIDTH - 2, with no wrap.
- Reset mid-XFER:
  - abort immediately; mem_en drops asynchronously;
  - words already written stay in memory; partial rd_line is cleared to 0;
  - no done pulse.
- While rst is high, mem_en = 0, so memory image loading is never disturbed.

Decomposition:
- Package mem_xfer_pkg:
  - state encoding IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2;
  - default LINE_WORDS and ADDR_WIDTH;
  - OFFSET_BITS derivation.
- No sub-module. The counter, FSM and line register are inline. The memory instance lives in the bench and top level, not in this block.

Test Plan:
- Fill, memory preloaded with mem word i = 16'h1000+i:
  - req_addr = 16'h0024 (base 16'h0020), req_wr = 0;
  - mem_addr sequence is 0x20, 0x22, ..., 0x2E with mem_en = 1 and mem_wr = 0;
  - done on cycle t+9;
  - rd_line word k = 16'h1010+k.
- Write-back:
  - req_addr = 16'h0100, req_wr = 1, wr_line word k = 16'hA500+k;
  - 8 write cycles to 0x100..0x10E;
  - a subsequent fill of 0x0100 returns 16'hA500..16'hA507;
  - rd_line is unchanged by the write itself.
- Busy rejection: req_valid held high continuously with a new address during XFER.
  - Only one transfer runs; req_ready = 0 from t+1 to t+9.
  - The second request is accepted at t+10.
- Top-of-memory fill, req_addr = 16'hFFF0: last mem_addr = 16'hFFFE, no wrap to 0.
- Reset mid-transfer: assert rst (async, between edges) during word 3 of a write-back.
  - mem_en and mem_wr fall immediately; no done pulse; state IDLE.
  - Memory words 0..2 are updated and words 3..7 are unchanged.
- Protocol checker (all tests):
  - never mem_wr & ~mem_en;
  - mem_addr[0] always 0;
  - done is exactly one cycle per completed request;
  - all mem_* outputs are 0 while idle.
